// File: rtl/mouse_cursor_paint.sv
`default_nettype none
// ============================================================================
// Module   : mouse_cursor_paint
// Purpose  : Applies decoded mouse reports to a clamped cursor, cycles the
//            paint colour on middle-button presses, and paints/erases a
//            square brush footprint through a req/ack framebuffer port.
// Ports    : clk, rst_n                         clock, async active-low reset
//            btn_left/right/middle, delta_x/y,
//            data_valid                         mouse report + strobe
//            cursor_x, cursor_y, color          registered cursor state
//            fb_wr_req/addr/data, fb_wr_ack     framebuffer write port
//            busy, dropped                      status
// Revision : 1.0 - initial release
// ============================================================================
module mouse_cursor_paint #(
    parameter int XW         = 6,
    parameter int YW         = 6,
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 64,
    parameter int COLOR_W    = 3,
    parameter int COLOR_INIT = 1,
    parameter int BRUSH      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_middle,
    input  logic [7:0]         delta_x,
    input  logic [7:0]         delta_y,
    input  logic               data_valid,
    output logic [XW-1:0]      cursor_x,
    output logic [YW-1:0]      cursor_y,
    output logic [COLOR_W-1:0] color,
    output logic               fb_wr_req,
    output logic [XW+YW-1:0]   fb_wr_addr,
    output logic [COLOR_W-1:0] fb_wr_data,
    input  logic               fb_wr_ack,
    output logic               busy,
    output logic               dropped
);

    // Signed working width: wide enough for cursor + signed delta with margin.
    localparam int SW0 = (XW > YW) ? XW : YW;
    localparam int SW  = ((SW0 > 8) ? SW0 : 8) + 2;
    localparam int BCW = 2;  // brush counter width, BRUSH is 1..4

    localparam logic signed [SW-1:0] C_XMAX    = SW'(WIDTH - 1);
    localparam logic signed [SW-1:0] C_YMAX    = SW'(HEIGHT - 1);
    localparam logic [XW:0]          C_WIDTH   = (XW + 1)'(WIDTH);
    localparam logic [YW:0]          C_HEIGHT  = (YW + 1)'(HEIGHT);
    localparam logic [BCW-1:0]       C_BMAX    = BCW'(BRUSH - 1);
    localparam logic [COLOR_W-1:0]   C_COL_TOP = '1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MOVE     = 2'd1,
        S_PAINT    = 2'd2,
        S_WAIT_ACK = 2'd3
    } state_t;

    state_t               state_q;
    logic [XW-1:0]        cursor_x_q, cursor_x_d;
    logic [YW-1:0]        cursor_y_q, cursor_y_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic                 prev_middle_q;
    logic                 left_q, right_q, middle_q;
    logic [7:0]           dx_q, dy_q;
    logic [BCW-1:0]       bx_q, by_q;
    logic                 last_q;
    logic                 req_q;
    logic [XW+YW-1:0]     addr_q;
    logic [COLOR_W-1:0]   data_q;
    logic                 dropped_q;

    logic signed [SW-1:0] w_sum_x, w_sum_y;
    logic [XW:0]          w_px;
    logic [YW:0]          w_py;
    logic                 w_pix_ok;
    logic                 w_last;

    // Cursor update with clamping, and colour stepping that skips index 0.
    always_comb begin
        w_sum_x = $signed({{(SW - XW){1'b0}}, cursor_x_q})
                + $signed({{(SW - 8){dx_q[7]}}, dx_q});
        // Positive Y delta moves up the screen, i.e. towards row 0.
        w_sum_y = $signed({{(SW - YW){1'b0}}, cursor_y_q})
                - $signed({{(SW - 8){dy_q[7]}}, dy_q});

        if (w_sum_x[SW-1])         cursor_x_d = '0;
        else if (w_sum_x > C_XMAX) cursor_x_d = XW'(WIDTH - 1);
        else                       cursor_x_d = w_sum_x[XW-1:0];

        if (w_sum_y[SW-1])         cursor_y_d = '0;
        else if (w_sum_y > C_YMAX) cursor_y_d = YW'(HEIGHT - 1);
        else                       cursor_y_d = w_sum_y[YW-1:0];

        color_d = color_q;
        if (middle_q && !prev_middle_q) begin
            color_d = (color_q == C_COL_TOP) ? COLOR_W'(1) : color_q + 1'b1;
        end
    end

    // Brush pixel under the counters; one extra bit catches right/bottom overflow.
    always_comb begin
        w_px     = {1'b0, cursor_x_q} + {{(XW + 1 - BCW){1'b0}}, bx_q};
        w_py     = {1'b0, cursor_y_q} + {{(YW + 1 - BCW){1'b0}}, by_q};
        w_pix_ok = (w_px < C_WIDTH) && (w_py < C_HEIGHT);
        w_last   = (bx_q == C_BMAX) && (by_q == C_BMAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cursor_x_q    <= XW'(WIDTH / 2);
            cursor_y_q    <= YW'(HEIGHT / 2);
            color_q       <= COLOR_W'(COLOR_INIT);
            prev_middle_q <= 1'b0;
            left_q        <= 1'b0;
            right_q       <= 1'b0;
            middle_q      <= 1'b0;
            dx_q          <= '0;
            dy_q          <= '0;
            bx_q          <= '0;
            by_q          <= '0;
            last_q        <= 1'b0;
            req_q         <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            dropped_q     <= 1'b0;
        end else begin
            // Reports arriving mid-operation are discarded; only flag them.
            dropped_q <= data_valid && (state_q != S_IDLE);

            case (state_q)
                S_IDLE: begin
                    if (data_valid) begin
                        left_q   <= btn_left;
                        right_q  <= btn_right;
                        middle_q <= btn_middle;
                        dx_q     <= delta_x;
                        dy_q     <= delta_y;
                        state_q  <= S_MOVE;
                    end
                end

                S_MOVE: begin
                    cursor_x_q    <= cursor_x_d;
                    cursor_y_q    <= cursor_y_d;
                    color_q       <= color_d;
                    prev_middle_q <= middle_q;
                    bx_q          <= '0;
                    by_q          <= '0;
                    state_q       <= (left_q || right_q) ? S_PAINT : S_IDLE;
                end

                S_PAINT: begin
                    if (w_pix_ok) begin
                        req_q  <= 1'b1;
                        addr_q <= {w_py[YW-1:0], w_px[XW-1:0]};
                        data_q <= left_q ? color_q : '0;
                    end
                    last_q <= w_last;
                    if (bx_q == C_BMAX) begin
                        bx_q <= '0;
                        by_q <= by_q + 1'b1;
                    end else begin
                        bx_q <= bx_q + 1'b1;
                    end
                    if (w_pix_ok)    state_q <= S_WAIT_ACK;
                    else if (w_last) state_q <= S_IDLE;
                end

                S_WAIT_ACK: begin
                    if (fb_wr_ack) begin
                        req_q   <= 1'b0;
                        state_q <= last_q ? S_IDLE : S_PAINT;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cursor_x   = cursor_x_q;
    assign cursor_y   = cursor_y_q;
    assign color      = color_q;
    assign fb_wr_req  = req_q;
    assign fb_wr_addr = addr_q;
    assign fb_wr_data = data_q;
    assign busy       = (state_q != S_IDLE);
    assign dropped    = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_mouse_cursor_paint.sv
`default_nettype none
// ============================================================================
// Module   : tb_mouse_cursor_paint
// Purpose  : Self-checking bench for mouse_cursor_paint: directed scenarios
//            plus randomized reports compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mouse_cursor_paint;

    localparam int XW = 6, YW = 6, WIDTH = 64, HEIGHT = 64;
    localparam int COLOR_W = 3, COLOR_INIT = 1, BRUSH = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               btn_left = 1'b0, btn_right = 1'b0, btn_middle = 1'b0;
    logic [7:0]         delta_x = '0, delta_y = '0;
    logic               data_valid = 1'b0;
    logic               fb_wr_ack = 1'b0;
    logic [XW-1:0]      cursor_x;
    logic [YW-1:0]      cursor_y;
    logic [COLOR_W-1:0] color;
    logic               fb_wr_req;
    logic [XW+YW-1:0]   fb_wr_addr;
    logic [COLOR_W-1:0] fb_wr_data;
    logic               busy, dropped;

    mouse_cursor_paint #(
        .XW(XW), .YW(YW), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .COLOR_W(COLOR_W), .COLOR_INIT(COLOR_INIT), .BRUSH(BRUSH)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .btn_left(btn_left), .btn_right(btn_right), .btn_middle(btn_middle),
        .delta_x(delta_x), .delta_y(delta_y), .data_valid(data_valid),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .color(color),
        .fb_wr_req(fb_wr_req), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
        .fb_wr_ack(fb_wr_ack), .busy(busy), .dropped(dropped)
    );

    initial forever #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_x, m_y, m_col, m_prev;
    int exp_q[$];
    int act_q[$];
    int ack_delay = 0;
    int drop_cnt  = 0;
    bit skip_hold = 1'b1;

    // Framebuffer-side monitor state
    int               ack_cnt = 0;
    logic             p_wait  = 1'b0;
    logic [XW+YW-1:0] p_addr  = '0;
    logic [COLOR_W-1:0] p_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Framebuffer responder: acks after ack_delay waiting cycles, logs
    // accepted writes and checks request hold while a write is pending.
    initial begin
        forever begin
            @(negedge clk);
            if (dropped) drop_cnt++;
            if (!rst_n || skip_hold) begin
                p_wait    = 1'b0;
                ack_cnt   = 0;
                fb_wr_ack = 1'b0;
            end else begin
                if (p_wait) begin
                    chk("hold_req",  32'(fb_wr_req),  32'(1));
                    chk("hold_addr", 32'(fb_wr_addr), 32'(p_addr));
                    chk("hold_data", 32'(fb_wr_data), 32'(p_data));
                end
                fb_wr_ack = fb_wr_req && (ack_cnt >= ack_delay);
                if (fb_wr_req && fb_wr_ack) begin
                    act_q.push_back(int'({fb_wr_addr, fb_wr_data}));
                    ack_cnt = 0;
                end else if (fb_wr_req) begin
                    ack_cnt++;
                end else begin
                    ack_cnt = 0;
                end
                p_wait = fb_wr_req && !fb_wr_ack;
                p_addr = fb_wr_addr;
                p_data = fb_wr_data;
            end
        end
    end

    function automatic int clampi(input int v, input int hi);
        if (v < 0)  return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic do_reset();
        skip_hold  = 1'b1;
        rst_n      = 1'b0;
        data_valid = 1'b0;
        btn_left   = 1'b0; btn_right = 1'b0; btn_middle = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        skip_hold = 1'b0;
        m_x = WIDTH / 2; m_y = HEIGHT / 2; m_col = COLOR_INIT; m_prev = 0;
        exp_q.delete(); act_q.delete(); drop_cnt = 0;
    endtask

    // One report; inj>0 injects a discarded report inj cycles after the strobe.
    task automatic do_report(input bit l, input bit r, input bit m,
                             input int dx, input int dy, input int inj);
        int nw, ns, k, first_req, exp_k;
        bit timeout;
        m_x = clampi(m_x + dx, WIDTH - 1);
        m_y = clampi(m_y - dy, HEIGHT - 1);
        if (m && !m_prev) m_col = (m_col == (1 << COLOR_W) - 1) ? 1 : m_col + 1;
        m_prev = m;
        nw = 0; ns = 0;
        if (l || r) begin
            for (int by = 0; by < BRUSH; by++) begin
                for (int bx = 0; bx < BRUSH; bx++) begin
                    if (m_x + bx < WIDTH && m_y + by < HEIGHT) begin
                        exp_q.push_back(((m_y + by) << (XW + COLOR_W)) |
                                        ((m_x + bx) << COLOR_W) | (l ? m_col : 0));
                        nw++;
                    end else begin
                        ns++;
                    end
                end
            end
        end
        exp_k = (l || r) ? 2 + 2 * nw + ns : 2;

        btn_left = l; btn_right = r; btn_middle = m;
        delta_x = 8'(dx); delta_y = 8'(dy); data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        k = 1; first_req = 0; timeout = 1'b0;
        forever begin
            if (fb_wr_req && first_req == 0) first_req = k;
            if (!busy) break;
            if (k >= 2000) begin timeout = 1'b1; break; end
            if (k == inj) begin
                btn_left = ~l; btn_middle = ~m;
                delta_x = 8'd20; delta_y = 8'd20; data_valid = 1'b1;
                @(negedge clk);
                data_valid = 1'b0; k++;
                chk("drop_pulse", 32'(dropped), 32'(1));
            end else begin
                @(negedge clk); k++;
            end
        end
        chk("timeout", 32'(timeout), 32'(0));
        if (l || r) chk("first_req_cycle", 32'(first_req), 32'(3));
        if (ack_delay == 0 && inj == 0) chk("busy_len", 32'(k), 32'(exp_k));
        chk("cursor_x", 32'(cursor_x), 32'(m_x));
        chk("cursor_y", 32'(cursor_y), 32'(m_y));
        chk("color",    32'(color),    32'(m_col));
        chk("req_idle", 32'(fb_wr_req), 32'(0));
        chk("n_writes", 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            chk("write", 32'(act_q[i]), 32'(exp_q[i]));
        chk("drop_count", 32'(drop_cnt), 32'((inj > 0) ? 1 : 0));
        exp_q.delete(); act_q.delete(); drop_cnt = 0;
    endtask

    initial begin
        int col_seq[7];
        int k;
        col_seq = '{2, 3, 4, 5, 6, 7, 1};

        do_reset();
        chk("rst_x",       32'(cursor_x),   32'(32));
        chk("rst_y",       32'(cursor_y),   32'(32));
        chk("rst_color",   32'(color),      32'(1));
        chk("rst_req",     32'(fb_wr_req),  32'(0));
        chk("rst_addr",    32'(fb_wr_addr), 32'(0));
        chk("rst_data",    32'(fb_wr_data), 32'(0));
        chk("rst_busy",    32'(busy),       32'(0));
        chk("rst_dropped", 32'(dropped),    32'(0));

        // Plain move
        do_report(0, 0, 0, 5, 3, 0);
        chk("tp_move_x", 32'(cursor_x), 32'(37));
        chk("tp_move_y", 32'(cursor_y), 32'(29));

        // Clamp at both X edges
        do_reset();
        repeat (3) do_report(0, 0, 0, -128, 0, 0);
        chk("tp_clamp_lo", 32'(cursor_x), 32'(0));
        repeat (2) do_report(0, 0, 0, 127, 0, 0);
        chk("tp_clamp_hi", 32'(cursor_x), 32'(63));

        // Paint then erase at (32,32)
        do_reset();
        do_report(1, 0, 0, 0, 0, 0);
        do_report(0, 1, 0, 0, 0, 0);
        do_report(1, 1, 0, 0, 0, 0);

        // Corner brush is clipped to a single pixel
        do_reset();
        do_report(1, 0, 0, 127, -127, 0);

        // Colour cycling, and a held middle only steps once
        do_reset();
        for (int i = 0; i < 7; i++) begin
            do_report(0, 0, 1, 0, 0, 0);
            chk("tp_color_seq", 32'(color), 32'(col_seq[i]));
            do_report(0, 0, 0, 0, 0, 0);
        end
        do_report(0, 0, 1, 0, 0, 0);
        do_report(0, 0, 1, 0, 0, 0);
        chk("tp_color_held", 32'(color), 32'(2));

        // Slow acks plus a report arriving during painting
        do_reset();
        ack_delay = 5;
        do_report(1, 0, 0, 0, 0, 5);
        do_report(1, 0, 1, -3, 7, 9);
        ack_delay = 0;

        // Randomized reports
        for (int i = 0; i < 60; i++) begin
            ack_delay = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            do_report(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                      ($urandom_range(0, 7) == 0) ? 1 : 0);
        end

        // Asynchronous reset while a write is pending
        ack_delay = 8;
        btn_left = 1'b1; btn_right = 1'b0; btn_middle = 1'b0;
        delta_x = 8'd0; delta_y = 8'd0; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        k = 0;
        while (!fb_wr_req && k < 20) begin @(negedge clk); k++; end
        chk("arst_req_seen", 32'(fb_wr_req), 32'(1));
        skip_hold = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",  32'(fb_wr_req), 32'(0));
        chk("arst_busy", 32'(busy),      32'(0));
        ack_delay = 0;
        do_reset();
        chk("arst_x", 32'(cursor_x), 32'(32));
        do_report(1, 0, 0, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
